// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roll controller and its helpers.
package dice_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROLL   = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int FACES_DEFAULT = 6;
    localparam int VALUE_W       = 4;

endpackage

// File: rtl/edge_detect.sv
// Registers a synchronous level and flags its rising and falling edges.
// RESET_VAL lets a level that is already high at reset count as "seen".
module edge_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= RESET_VAL;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;
    assign fall = ~d & d_q;

endmodule

// File: rtl/dice_roll_ctrl.sv
// Dice roll controller: fast face cycling while the button is held, a
// decelerating tumble after release, then a one-cycle done strobe.
module dice_roll_ctrl
    import dice_pkg::*;
#(
    parameter int FACES        = FACES_DEFAULT,
    parameter int TICK_DIV     = 16,
    parameter int SETTLE_STEPS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn,
    output logic [VALUE_W-1:0] value,
    output logic               rolling,
    output logic               done
);

    // div must reach the longest settle period minus one: TICK_DIV*(SETTLE_STEPS+1)-1
    localparam int DIV_W  = $clog2(TICK_DIV * (SETTLE_STEPS + 1));
    localparam int STEP_W = $clog2(SETTLE_STEPS + 1);

    localparam logic [DIV_W-1:0]  ROLL_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SETTLE_STEPS - 1);

    function automatic logic [VALUE_W-1:0] next_face(input logic [VALUE_W-1:0] v);
        return (v == VALUE_W'(FACES)) ? VALUE_W'(1) : v + VALUE_W'(1);
    endfunction

    state_t             state;
    state_t             next_state;
    logic [DIV_W-1:0]   div;
    logic [STEP_W-1:0]  step;
    logic [DIV_W-1:0]   settle_last;
    logic               rise;
    logic               fall;
    logic               roll_tc;
    logic               settle_tc;
    logic               step_last;
    logic               div_clr;
    logic               div_inc;
    logic               step_clr;
    logic               step_inc;
    logic               adv;
    logic               rolling_d;
    logic               done_d;

    // Reset value 1 means a button held through reset needs a fresh press.
    edge_detect #(
        .RESET_VAL (1'b1)
    ) u_btn_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (btn),
        .rise (rise),
        .fall (fall)
    );

    // Settle period for step s is TICK_DIV*(s+2) cycles.
    assign settle_last = DIV_W'(TICK_DIV * (int'(step) + 2) - 1);
    assign roll_tc     = (div == ROLL_LAST);
    assign settle_tc   = (div == settle_last);
    assign step_last   = (step == STEP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (rise) next_state = ROLL;
            ROLL:    if (fall) next_state = SETTLE;
            SETTLE: begin
                if (rise) begin
                    next_state = ROLL;
                end else if (settle_tc && step_last) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = rise ? ROLL : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        div_clr  = 1'b0;
        div_inc  = 1'b0;
        step_clr = 1'b0;
        step_inc = 1'b0;
        adv      = 1'b0;
        unique case (state)
            IDLE: div_clr = rise;
            ROLL: begin
                if (fall) begin
                    div_clr  = 1'b1;
                    step_clr = 1'b1;
                end else if (roll_tc) begin
                    adv     = 1'b1;
                    div_clr = 1'b1;
                end else begin
                    div_inc = 1'b1;
                end
            end
            SETTLE: begin
                // A re-press wins over an advance falling on the same edge.
                if (rise) begin
                    div_clr  = 1'b1;
                    step_clr = 1'b1;
                end else if (settle_tc) begin
                    adv      = 1'b1;
                    div_clr  = 1'b1;
                    step_inc = 1'b1;
                end else begin
                    div_inc = 1'b1;
                end
            end
            DONE:    div_clr = rise;
            default: div_clr = 1'b1;
        endcase
        rolling_d = (next_state == ROLL) || (next_state == SETTLE);
        done_d    = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value   <= VALUE_W'(1);
            div     <= '0;
            step    <= '0;
            rolling <= 1'b0;
            done    <= 1'b0;
        end else begin
            if (div_clr) begin
                div <= '0;
            end else if (div_inc) begin
                div <= div + DIV_W'(1);
            end
            if (step_clr) begin
                step <= '0;
            end else if (step_inc) begin
                step <= step + STEP_W'(1);
            end
            if (adv) begin
                value <= next_face(value);
            end
            rolling <= rolling_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Directed bench for dice_roll_ctrl with FACES=6, TICK_DIV=4, SETTLE_STEPS=3.
module tb_dice_roll_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic [3:0] value;
    logic       rolling;
    logic       done;

    int total = 0;
    int bad   = 0;

    dice_roll_ctrl #(
        .FACES        (6),
        .TICK_DIV     (4),
        .SETTLE_STEPS (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn),
        .value   (value),
        .rolling (rolling),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (value !== 4'd1) begin bad++; $display("FAIL reset_value got=%0d want=1", value); end
        total++;
        if (rolling !== 1'b0) begin bad++; $display("FAIL reset_rolling got=%b want=0", rolling); end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (rolling !== 1'b0 || value !== 4'd1) begin
                bad++; $display("FAIL idle_quiet rolling=%b value=%0d want 0/1", rolling, value);
            end
        end
    endtask

    task automatic test_hold();
        int exp;
        btn = 1'b1;
        tick();
        total++;
        if (rolling !== 1'b1 || value !== 4'd1) begin
            bad++; $display("FAIL hold_start rolling=%b value=%0d want 1/1", rolling, value);
        end
        for (int k = 1; k <= 24; k++) begin
            tick();
            exp = ((k / 4) % 6) + 1;
            total++;
            if (value !== 4'(exp) || rolling !== 1'b1 || done !== 1'b0) begin
                bad++; $display("FAIL hold_k%0d value=%0d rolling=%b done=%b want %0d/1/0", k, value, rolling, done, exp);
            end
        end
    endtask

    task automatic test_settle();
        int exp;
        btn = 1'b0;
        tick();
        total++;
        if (rolling !== 1'b1 || value !== 4'd1) begin
            bad++; $display("FAIL settle_fall rolling=%b value=%0d want 1/1", rolling, value);
        end
        for (int j = 1; j <= 36; j++) begin
            tick();
            exp = (j < 8) ? 1 : (j < 20) ? 2 : (j < 36) ? 3 : 4;
            total++;
            if (value !== 4'(exp) || done !== 1'b0 || rolling !== (j < 36)) begin
                bad++; $display("FAIL settle_j%0d value=%0d rolling=%b done=%b want %0d/%b/0", j, value, rolling, done, exp, j < 36);
            end
        end
        tick();
        total++;
        if (done !== 1'b1 || rolling !== 1'b0 || value !== 4'd4) begin
            bad++; $display("FAIL done_strobe done=%b rolling=%b value=%0d want 1/0/4", done, rolling, value);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (done !== 1'b0 || rolling !== 1'b0 || value !== 4'd4) begin
                bad++; $display("FAIL after_done done=%b rolling=%b value=%0d want 0/0/4", done, rolling, value);
            end
        end
    endtask

    task automatic test_repress_settle();
        int exp;
        btn = 1'b1;
        tick();
        for (int k = 1; k <= 4; k++) tick();
        total++;
        if (value !== 4'd5) begin bad++; $display("FAIL repress_roll value=%0d want=5", value); end
        btn = 1'b0;
        tick();
        for (int j = 1; j <= 9; j++) begin
            tick();
            exp = (j < 8) ? 5 : 6;
            total++;
            if (value !== 4'(exp) || done !== 1'b0) begin
                bad++; $display("FAIL repress_settle_j%0d value=%0d done=%b want %0d/0", j, value, done, exp);
            end
        end
        btn = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            tick();
            exp = (k < 4) ? 6 : 1;
            total++;
            if (value !== 4'(exp) || rolling !== 1'b1 || done !== 1'b0) begin
                bad++; $display("FAIL repress_k%0d value=%0d rolling=%b done=%b want %0d/1/0", k, value, rolling, done, exp);
            end
        end
    endtask

    task automatic test_rise_priority();
        int exp;
        btn = 1'b0;
        tick();
        for (int j = 1; j <= 7; j++) tick();
        btn = 1'b1;
        tick();
        total++;
        if (value !== 4'd1 || rolling !== 1'b1) begin
            bad++; $display("FAIL rise_vs_adv value=%0d rolling=%b want 1/1", value, rolling);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp = (k < 4) ? 1 : 2;
            total++;
            if (value !== 4'(exp)) begin
                bad++; $display("FAIL rise_prio_k%0d value=%0d want=%0d", k, value, exp);
            end
        end
    endtask

    task automatic test_rise_in_done();
        btn = 1'b0;
        tick();
        for (int j = 1; j <= 36; j++) tick();
        total++;
        if (value !== 4'd5 || rolling !== 1'b0) begin
            bad++; $display("FAIL done_entry value=%0d rolling=%b want 5/0", value, rolling);
        end
        btn = 1'b1;
        tick();
        total++;
        if (rolling !== 1'b1 || value !== 4'd5) begin
            bad++; $display("FAIL rise_in_done rolling=%b value=%0d want 1/5", rolling, value);
        end
        for (int k = 1; k <= 4; k++) tick();
        total++;
        if (value !== 4'd6 || rolling !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL done_reroll value=%0d rolling=%b done=%b want 6/1/0", value, rolling, done);
        end
    endtask

    task automatic test_reset_hold();
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (value !== 4'd1 || rolling !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL async_rst value=%0d rolling=%b done=%b want 1/0/0", value, rolling, done);
        end
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (rolling !== 1'b0 || value !== 4'd1) begin
                bad++; $display("FAIL held_thru_rst rolling=%b value=%0d want 0/1", rolling, value);
            end
        end
        btn = 1'b0;
        tick();
        btn = 1'b1;
        tick();
        total++;
        if (rolling !== 1'b1) begin bad++; $display("FAIL fresh_press rolling=%b want=1", rolling); end
    endtask

    task automatic test_reset_settle();
        for (int k = 1; k <= 16; k++) tick();
        btn = 1'b0;
        tick();
        for (int j = 0; j < 3; j++) tick();
        total++;
        if (value !== 4'd5 || rolling !== 1'b1) begin
            bad++; $display("FAIL pre_abort value=%0d rolling=%b want 5/1", value, rolling);
        end
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (value !== 4'd1 || rolling !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL abort_rst value=%0d rolling=%b done=%b want 1/0/0", value, rolling, done);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 45; i++) begin
            tick();
            total++;
            if (done !== 1'b0 || rolling !== 1'b0 || value !== 4'd1) begin
                bad++; $display("FAIL aborted_quiet done=%b rolling=%b value=%0d want 0/0/1", done, rolling, value);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        btn = 1'b0;
        test_reset();
        test_hold();
        test_settle();
        test_repress_settle();
        test_rise_priority();
        test_rise_in_done();
        test_reset_hold();
        test_reset_settle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
